// File: rtl/mc_defs.sv
// mc_defs: state encodings, opcode/funct constants and ALU control codes shared by the
// multicycle MIPS controller.
package mc_defs;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_HALT    = 4'd15
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: R-type funct to alucontrol decode with a legal-funct flag.
module mc_aludec
  import mc_defs::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       legal
);
  always_comb begin
    alucontrol = funct == F_SUB ? ALU_SUB :
                 funct == F_AND ? ALU_AND :
                 funct == F_OR  ? ALU_OR  :
                 funct == F_SLT ? ALU_SLT : ALU_ADD;
    legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore-style multicycle MIPS control FSM with memory wait states,
// access timeout, illegal-instruction trap and a per-instruction retire strobe.
module mc_controller
  import mc_defs::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_o
);
  state_t state, nxt, dec_nxt;
  logic [CNT_W-1:0] cnt;
  logic pcwrite, branch, wait_c, tmo, set_ill, fn_legal;
  logic [2:0] fn_alu;
  mc_aludec u_aludec (.funct(funct), .alucontrol(fn_alu), .legal(fn_legal));
  assign wait_c = (state == S_FETCH || state == S_MEMRD || state == S_MEMWR) && !mem_ready;
  assign tmo = wait_c && cnt == CNT_W'(TIMEOUT - 1);
  assign dec_nxt = (op == OP_LW || op == OP_SW)       ? S_MEMADR  :
                   (op == OP_RTYPE && funct == F_JR) ? S_JR      :
                   (op == OP_RTYPE && fn_legal)      ? S_EXECUTE :
                   op == OP_BEQ                      ? S_BRANCH  :
                   op == OP_ADDI                     ? S_ADDIEX  :
                   op == OP_J                        ? S_JUMP    : S_HALT;
  assign pcen = pcwrite | (branch & zero);
  assign state_o = state;
  always_comb begin
    nxt = state;
    pcwrite = 1'b0;
    branch = 1'b0;
    iord = 1'b0;
    irwrite = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    alucontrol = ALU_ADD;
    retire = 1'b0;
    set_ill = 1'b0;
    case (state)
      S_FETCH: begin
        // reset parks the FSM here, so the ready-qualified strobes must also see reset
        alusrcb = 2'b01;
        irwrite = reset & mem_ready;
        pcwrite = reset & mem_ready;
        nxt = mem_ready ? S_DECODE : tmo ? S_HALT : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        nxt = dec_nxt;
        set_ill = dec_nxt == S_HALT;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt = op == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        nxt = mem_ready ? S_MEMWB : tmo ? S_HALT : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire = 1'b1;
        nxt = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        memwrite = 1'b1;
        retire = mem_ready;
        nxt = mem_ready ? S_FETCH : tmo ? S_HALT : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        alucontrol = fn_alu;
        nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        regwrite = 1'b1;
        retire = 1'b1;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc = 2'b01;
        branch = 1'b1;
        retire = 1'b1;
        nxt = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire = 1'b1;
        nxt = S_FETCH;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
        retire = 1'b1;
        nxt = S_FETCH;
      end
      S_JR: begin
        pcsrc = 2'b11;
        pcwrite = 1'b1;
        retire = 1'b1;
        nxt = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      cnt <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : wait_c ? cnt + 1'b1 : cnt;
      illegal <= illegal | set_ill;
      bus_err <= bus_err | tmo;
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized self-checking bench; expected behaviour per instruction is
// derived from cycle budgets (latency, wait states) rather than from the FSM itself.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, retire, illegal, bus_err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;
  int n_cmp = 0, n_bad = 0;

  mc_controller #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .retire(retire), .illegal(illegal), .bus_err(bus_err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // instruction kinds: 0 add 1 sub 2 and 3 or 4 slt 5 lw 6 sw 7 beq 8 addi 9 j 10 jr
  function automatic logic [5:0] op_of(input int k);
    case (k)
      5: return 6'b100011;
      6: return 6'b101011;
      7: return 6'b000100;
      8: return 6'b001000;
      9: return 6'b000010;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] funct_of(input int k);
    case (k)
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      10: return 6'b001000;
      default: return 6'b100000;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input int k);
    case (k)
      1, 7: return 3'b110;
      2: return 3'b000;
      3: return 3'b001;
      4: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    op = 6'b000000;
    funct = 6'b100000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    #2;
    n_cmp += 6;
    if (state_o !== 4'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state_o); end
    if (irwrite !== 1'b0) begin n_bad++; $display("FAIL reset_irwrite got %b want 0", irwrite); end
    if (pcen !== 1'b0) begin n_bad++; $display("FAIL reset_pcen got %b want 0", pcen); end
    if ({memwrite, regwrite, retire} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes got %b want 000", {memwrite, regwrite, retire}); end
    if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", illegal); end
    if (bus_err !== 1'b0) begin n_bad++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    do_reset();
  endtask

  // Runs one instruction from FETCH; fw wait cycles in FETCH, mw in the data access.
  task automatic test_instr(input int k, input int fw, input int mw, input logic z);
    int lat, n_ir, n_rw, n_mw, n_pc, n_m2r, e_lat, e_mw;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic rdst, m2r_rt, pcen_rt;
    bit is_mem, is_r;
    is_mem = (k == 5 || k == 6);
    is_r = (k <= 4);
    op = op_of(k);
    funct = funct_of(k);
    zero = z;
    lat = -1; n_ir = 0; n_rw = 0; n_mw = 0; n_pc = 0; n_m2r = 0;
    alu = 3'bxxx; pcs = 2'bxx; rdst = 1'bx; m2r_rt = 1'bx; pcen_rt = 1'bx;
    for (int c = 0; c < 60 && lat < 0; c++) begin
      mem_ready = (c < fw || (is_mem && c >= fw + 3 && c < fw + 3 + mw)) ? 1'b0 : 1'b1;
      #1;
      if (irwrite) n_ir++;
      if (regwrite) begin n_rw++; if (memtoreg) n_m2r++; end
      if (memwrite) n_mw++;
      if (pcen) n_pc++;
      if (alusrca && alusrcb == 2'b00) alu = alucontrol;
      if (retire) begin lat = c + 1; pcs = pcsrc; rdst = regdst; m2r_rt = memtoreg; pcen_rt = pcen; end
      tick();
    end
    e_lat = ((k == 7 || k >= 9) ? 3 : (k == 5) ? 5 : 4) + fw + (is_mem ? mw : 0);
    e_mw = (k == 6) ? mw + 1 : 0;
    n_cmp += 6;
    if (lat != e_lat) begin n_bad++; $display("FAIL latency kind=%0d fw=%0d mw=%0d got %0d want %0d", k, fw, mw, lat, e_lat); end
    if (n_ir != 1) begin n_bad++; $display("FAIL irwrite_count kind=%0d got %0d want 1", k, n_ir); end
    if (n_rw != ((k == 6 || k == 7 || k >= 9) ? 0 : 1)) begin n_bad++; $display("FAIL regwrite_count kind=%0d got %0d", k, n_rw); end
    if (n_mw != e_mw) begin n_bad++; $display("FAIL memwrite_cycles kind=%0d got %0d want %0d", k, n_mw, e_mw); end
    if (n_pc != 1 + ((k >= 9 || (k == 7 && z)) ? 1 : 0)) begin n_bad++; $display("FAIL pcen_count kind=%0d z=%b got %0d", k, z, n_pc); end
    if (n_m2r != (k == 5 ? 1 : 0)) begin n_bad++; $display("FAIL memtoreg_count kind=%0d got %0d", k, n_m2r); end
    if (is_r || k == 7) begin
      n_cmp++;
      if (alu !== alu_of(k)) begin n_bad++; $display("FAIL alucontrol kind=%0d got %b want %b", k, alu, alu_of(k)); end
    end
    if (k == 7 || k >= 9) begin
      n_cmp += 2;
      if (pcs !== (k == 7 ? 2'b01 : k == 9 ? 2'b10 : 2'b11)) begin n_bad++; $display("FAIL pcsrc kind=%0d got %b", k, pcs); end
      if (pcen_rt !== (k == 7 ? z : 1'b1)) begin n_bad++; $display("FAIL pcen_at_retire kind=%0d z=%b got %b", k, z, pcen_rt); end
    end
    if (is_r || k == 5 || k == 8) begin
      n_cmp += 2;
      if (rdst !== (is_r ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL regdst kind=%0d got %b", k, rdst); end
      if (m2r_rt !== (k == 5 ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL memtoreg kind=%0d got %b", k, m2r_rt); end
    end
    n_cmp++;
    if ({illegal, bus_err} !== 2'b00) begin n_bad++; $display("FAIL sticky_flags kind=%0d got %b want 00", k, {illegal, bus_err}); end
  endtask

  task automatic test_mix();
    test_instr(0, 0, 0, 1'b0);
    test_instr(5, 0, 0, 1'b0);
    test_instr(6, 0, 0, 1'b0);
    test_instr(7, 0, 0, 1'b1);
    test_instr(7, 0, 0, 1'b0);
    test_instr(9, 0, 0, 1'b0);
    test_instr(10, 0, 0, 1'b0);
  endtask

  task automatic test_wait();
    test_instr(5, 3, 2, 1'b0);
    test_instr(6, 2, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      test_instr(int'($urandom_range(0, 10)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_addi();
    do_reset();
    op = 6'b001000;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    n_cmp += 3;
    if (state_o !== 4'd9) begin n_bad++; $display("FAIL addiex_state got %0d want 9", state_o); end
    if ({alusrca, alusrcb} !== 3'b110) begin n_bad++; $display("FAIL addiex_src got %b want 110", {alusrca, alusrcb}); end
    if (regwrite !== 1'b0) begin n_bad++; $display("FAIL addiex_regwrite got %b want 0", regwrite); end
    tick();
    n_cmp += 2;
    if (state_o !== 4'd10) begin n_bad++; $display("FAIL addiwb_state got %0d want 10", state_o); end
    if ({regdst, regwrite, memtoreg, retire} !== 4'b0101) begin n_bad++; $display("FAIL addiwb_ctl got %b want 0101", {regdst, regwrite, memtoreg, retire}); end
  endtask

  task automatic test_timeout();
    int n_ir;
    do_reset();
    n_ir = 0;
    for (int c = 0; c < 16; c++) begin
      mem_ready = 1'b0;
      #1;
      if (irwrite) n_ir++;
      if (c == 15) begin
        n_cmp++;
        if (state_o !== 4'd0) begin n_bad++; $display("FAIL timeout_pre_state got %0d want 0", state_o); end
      end
      tick();
    end
    n_cmp += 3;
    if (state_o !== 4'd15) begin n_bad++; $display("FAIL timeout_state got %0d want 15", state_o); end
    if (bus_err !== 1'b1) begin n_bad++; $display("FAIL timeout_bus_err got %b want 1", bus_err); end
    if (n_ir != 0) begin n_bad++; $display("FAIL timeout_irwrite got %0d want 0", n_ir); end
    do_reset();
    n_ir = 0;
    for (int c = 0; c < 16; c++) begin
      mem_ready = (c == 15);
      #1;
      if (irwrite) n_ir++;
      tick();
    end
    n_cmp += 3;
    if (state_o !== 4'd1) begin n_bad++; $display("FAIL late_ready_state got %0d want 1", state_o); end
    if (bus_err !== 1'b0) begin n_bad++; $display("FAIL late_ready_bus_err got %b want 0", bus_err); end
    if (n_ir != 1) begin n_bad++; $display("FAIL late_ready_irwrite got %0d want 1", n_ir); end
    do_reset();
    op = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 16; c++) tick();
    n_cmp += 2;
    if (state_o !== 4'd15 || bus_err !== 1'b1) begin n_bad++; $display("FAIL memwr_timeout got state=%0d bus_err=%b want 15/1", state_o, bus_err); end
    if (memwrite !== 1'b0) begin n_bad++; $display("FAIL memwr_timeout_memwrite got %b want 0", memwrite); end
  endtask

  task automatic test_illegal(input logic [5:0] o, input logic [5:0] f);
    int n_str;
    do_reset();
    op = o;
    funct = f;
    mem_ready = 1'b1;
    tick();
    n_cmp++;
    if (state_o !== 4'd1) begin n_bad++; $display("FAIL illegal_decode op=%b f=%b got %0d want 1", o, f, state_o); end
    tick();
    n_cmp += 2;
    if (state_o !== 4'd15) begin n_bad++; $display("FAIL illegal_halt op=%b f=%b got %0d want 15", o, f, state_o); end
    if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_flag op=%b f=%b got %b want 1", o, f, illegal); end
    n_str = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      n_str += int'(irwrite) + int'(memwrite) + int'(regwrite) + int'(pcen) + int'(retire);
      tick();
    end
    n_cmp += 2;
    if (n_str != 0) begin n_bad++; $display("FAIL illegal_quiet op=%b f=%b got %0d strobes want 0", o, f, n_str); end
    if (state_o !== 4'd15 || illegal !== 1'b1 || bus_err !== 1'b0) begin n_bad++; $display("FAIL illegal_hold got state=%0d ill=%b be=%b", state_o, illegal, bus_err); end
  endtask

  task automatic test_reset_memwr();
    do_reset();
    op = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (memwrite !== 1'b1 || state_o !== 4'd5) begin n_bad++; $display("FAIL memwr_entry got memwrite=%b state=%0d want 1/5", memwrite, state_o); end
    repeat (2) tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({memwrite, regwrite, pcen} !== 3'b000) begin n_bad++; $display("FAIL async_reset_strobes got %b want 000", {memwrite, regwrite, pcen}); end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if ({irwrite, pcen} !== 2'b00) begin n_bad++; $display("FAIL reset_ready_gating got %b want 00", {irwrite, pcen}); end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0) begin n_bad++; $display("FAIL post_reset_state got %0d want 0", state_o); end
  endtask

  initial begin
    test_reset();
    test_mix();
    test_wait();
    test_random();
    test_addi();
    test_timeout();
    test_illegal(6'b111111, 6'b100000);
    test_illegal(6'b000000, 6'b000111);
    test_reset_memwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the MIPS core. Moore-style FSM sequencing a shared-ALU, shared-memory datapath.
- Holds an instruction register (IR) and A/B operand registers, plus a unified instruction/data memory with a `mem_ready` handshake.
- Supports lw, sw, beq, addi, j, jr and the R-type add/sub/and/or/slt.
- Adds memory wait-state handling, a timeout, illegal-instruction trapping and a retire strobe.

Parameters:
- TIMEOUT, 16: maximum consecutive wait cycles with `mem_ready`=0 in any memory state before a bus error.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcen  out  1  PC load enable = pcwrite | (branch & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  load IR from memory read data.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = Data register, 0 = ALUOut.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = A (jr).
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- retire  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  sticky; set on an undecodable instruction.
- bus_err  out  1  sticky; set on a memory timeout.
- state_o  out  4  current state, for debug.

Behaviour:
- **Reset** (reset=0, async): state=FETCH, wait counter=0, illegal=0, bus_err=0. All strobes are 0, including irwrite, pcen, memwrite and regwrite.
- **Release:** the first rising edge after reset=1 evaluates FETCH.
- **Default outputs:** every output not listed for a state is 0. alucontrol defaults to 010.
- **FETCH:** iord=0, alusrca=0, alusrcb=01, pcsrc=00, add.
  - irwrite and pcwrite are asserted only when mem_ready=1, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- **DECODE:** alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state:
  - op 100011/101011 → MEMADR.
  - op 000000, funct 001000 → JR.
  - op 000000, other legal funct → EXECUTE.
  - op 000100 → BRANCH.
  - op 001000 → ADDIEX.
  - op 000010 → JUMP.
  - anything else → HALT, and illegal←1.
- **MEMADR:** alusrca=1, alusrcb=10, add. Go to MEMRD if op=lw, else MEMWR.
- **MEMRD:** iord=1. Wait for mem_ready, then go to MEMWB.
- **MEMWB:** regdst=0, memtoreg=1, regwrite=1, retire=1, then FETCH.
- **MEMWR:** iord=1, memwrite held at 1 until the mem_ready cycle inclusive. Then retire=1 and go to FETCH.
- **EXECUTE:** alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). Then ALUWB.
- **ALUWB:** regdst=1, memtoreg=0, regwrite=1, retire=1, then FETCH.
- **BRANCH:** alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1, so pcen=zero. retire=1, then FETCH.
- **ADDIEX:** alusrca=1, alusrcb=10, add, then ADDIWB.
- **ADDIWB:** regdst=0, memtoreg=0, regwrite=1, retire=1, then FETCH.
- **JUMP:** pcsrc=10, pcwrite=1, retire=1, then FETCH.
- **JR:** pcsrc=11, pcwrite=1, retire=1, then FETCH.
- **HALT:** all strobes 0; the state persists until reset. illegal and bus_err hold their values.
- **Wait counter:**
  - Clears on any transition.
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - When the counter equals TIMEOUT-1 and mem_ready=0: next state HALT, bus_err←1, and memwrite drops in the HALT cycle.
  - mem_ready=1 on that same cycle wins: the access completes, with no error.
- **Latency with mem_ready=1 constantly** (cycles, fetch to retire):
  - beq, j, jr: 3.
  - R-type, sw, addi: 4.
  - lw: 5.
- **Reset mid-access:** memwrite, regwrite and pcen fall asynchronously with reset.
- **Outputs are registered-state decoded**, except pcen (depends on zero) and the mem_ready-qualified strobes in FETCH, MEMRD and MEMWR.

Decomposition:
- **Shared include `mc_defs`:**
  - State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JR=12, HALT=15.
  - Opcode and funct constants, and the alucontrol codes.
- **Sub-module `mc_aludec`:** combinational funct→alucontrol decode plus a funct-legal flag. Used by EXECUTE and by the DECODE legality check.

Test Plan:
- **Reset mid-MEMWR:** drive sw with mem_ready=0 for 2 cycles, then reset=0 → memwrite=0 immediately; after release, state_o=0.
- **Zero-wait instruction mix:** add, lw, sw, beq(taken, zero=1), beq(not taken, zero=0), j, jr with mem_ready=1 → retire spacing 4, 5, 4, 3, 3, 3, 3 cycles. pcen=1 in BRANCH only when zero=1. jr shows pcsrc=11 with pcen=1.
- **Wait states:** lw with mem_ready low for 3 cycles in FETCH and 2 in MEMRD → irwrite pulses exactly once, on the ready cycle; retire at cycle 10; regwrite=1 with memtoreg=1 once.
- **Timeout:** TIMEOUT=16, mem_ready stuck 0 in FETCH → HALT at the 16th wait cycle, bus_err=1, no irwrite. Repeat with mem_ready=1 on the 16th cycle → normal DECODE, bus_err=0.
- **Illegal instruction:**
  - op=111111 → DECODE then HALT, illegal=1, no further strobes for 20 cycles.
  - R-type funct 000111 → same response.
- **addi:** op=001000 → ADDIEX with alusrcb=10, then ADDIWB with regdst=0, regwrite=1, memtoreg=0.
